// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the branch predictor: entry layout and the
// weakly-taken counter initialisation value.
package branch_predictor_pkg;

  localparam int BP_DEF_IDX_W = 6;
  localparam int BP_DEF_CTR_W = 2;

  // Fields sized for the widest legal configuration; narrower tags and
  // counters are stored zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [3:0]  ctr;
  } bp_entry_t;

  function automatic logic [3:0] bp_weak_taken(input int ctr_w);
    return 4'(1 << (ctr_w - 1));
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Up/down saturating next-value logic for a CTR_W-bit direction counter.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             up_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and
// branch/misprediction statistics. Lookup is combinational; update is clocked.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_DEF_IDX_W,
  parameter int CTR_W = BP_DEF_CTR_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_if,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  input  logic             btb_clear,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int N = 1 << IDX_W;

  bp_entry_t        tbl_q [N];
  bp_entry_t        tbl_d [N];
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [29:0]      lk_tag, up_tag;
  bp_entry_t        lk_e, up_e;
  logic             lk_hit, up_hit;
  logic [CTR_W-1:0] ctr_nxt;

  assign lk_idx = pc_if[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign lk_tag = 30'(pc_if[31:IDX_W+2]);
  assign up_tag = 30'(upd_pc[31:IDX_W+2]);
  assign lk_e   = tbl_q[lk_idx];
  assign up_e   = tbl_q[up_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == lk_tag);
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  assign pred_taken  = lk_hit && lk_e.ctr[CTR_W-1];
  assign pred_target = pred_taken ? lk_e.target : pc_if + 32'd4;

  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && upd_pred_target != upd_target));

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .ctr_i (up_e.ctr[CTR_W-1:0]),
    .up_i  (upd_taken),
    .ctr_o (ctr_nxt)
  );

  // Clear has priority over allocation/training; statistics count regardless.
  always_comb begin
    tbl_d = tbl_q;
    if (btb_clear) begin
      for (int i = 0; i < N; i++) tbl_d[i].valid = 1'b0;
    end else if (upd_valid) begin
      if (up_hit) begin
        tbl_d[up_idx].ctr = 4'(ctr_nxt);
        if (upd_taken) tbl_d[up_idx].target = upd_target;
      end else if (upd_taken) begin
        tbl_d[up_idx].valid  = 1'b1;
        tbl_d[up_idx].tag    = up_tag;
        tbl_d[up_idx].target = upd_target;
        tbl_d[up_idx].ctr    = bp_weak_taken(CTR_W);
      end
    end
  end

  always_comb begin
    br_d  = br_q;
    mis_d = mis_q;
    if (upd_valid && br_q != '1) br_d = br_q + CNT_W'(1);
    if (mispredict && mis_q != '1) mis_d = mis_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      tbl_q <= tbl_d;
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign br_count      = br_q;
  assign mispred_count = mis_q;

  logic unused_bits;
  assign unused_bits = ^{pc_if[1:0], upd_pc[1:0], lk_e.ctr, up_e.ctr};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (IDX_W=6, CTR_W=2, CNT_W=4).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        btb_clear;
  logic        mispredict;
  logic [3:0]  br_count;
  logic [3:0]  mispred_count;

  branch_predictor #(.IDX_W(6), .CTR_W(2), .CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_if           (pc_if),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .btb_clear       (btb_clear),
    .mispredict      (mispredict),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_br  = 0;
  int   m_mis = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return {31'd0, pred_taken};
      1:       return pred_target;
      2:       return {31'd0, mispredict};
      3:       return {28'd0, br_count};
      default: return {28'd0, mispred_count};
    endcase
  endfunction

  // Monitor: outputs are stable at the falling edge; drain every pending check.
  chk_t        mc;
  logic [31:0] ma;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mc = q.pop_front();
      ma = actual(mc.sel);
      total++;
      if (ma !== mc.exp) begin
        bad++;
        $display("FAIL %s @%0t: got 0x%0h want 0x%0h", mc.name, $time, ma, mc.exp);
      end
    end
  end

  task automatic expect_v(input string n, input int s, input logic [31:0] e);
    chk_t c;
    c.name = n; c.sel = s; c.exp = e;
    q.push_back(c);
  endtask

  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    pc_if = pc;
    expect_v("pred_taken", 0, {31'd0, t});
    expect_v("pred_target", 1, tgt);
  endtask

  task automatic stats();
    expect_v("br_count", 3, 32'(m_br));
    expect_v("mispred_count", 4, 32'(m_mis));
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptg, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptg;
    expect_v("mispredict", 2, {31'd0, mis});
    if (m_br < 15) m_br++;
    if (mis && m_mis < 15) m_mis++;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    btb_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_if = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0; btb_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold predict, then allocate 0x100 -> 0x40 with a not-taken prediction
    stats(); look(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1); cycle();
    stats(); look(32'h100, 1'b1, 32'h40);
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1); cycle();      // ctr 2->1
    look(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); cycle();       // ctr 1->0
    look(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1); cycle();      // ctr 0->1
    look(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h44, 1'b0, 32'h0, 1'b1); cycle();      // ctr 1->2
    stats(); look(32'h100, 1'b1, 32'h44);
    upd(32'h100, 1'b1, 32'h48, 1'b1, 32'h44, 1'b1); cycle();     // wrong target
    look(32'h100, 1'b1, 32'h48);
    upd(32'h100, 1'b1, 32'h48, 1'b1, 32'h48, 1'b0); cycle();     // correct
    // Aliasing: same-cycle lookup sees pre-update contents
    stats(); look(32'h100, 1'b1, 32'h48);
    upd(32'h200, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1); cycle();
    look(32'h100, 1'b0, 32'h104);
    upd(32'h304, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); cycle();
    look(32'h304, 1'b0, 32'h308); cycle();
    look(32'h202, 1'b1, 32'h80); cycle();
    // Clear wins over a simultaneous taken update
    look(32'h200, 1'b1, 32'h80);
    btb_clear = 1'b1;
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1); cycle();
    stats(); look(32'h200, 1'b0, 32'h204); cycle();
    look(32'h100, 1'b0, 32'h104); cycle();
    // Statistics saturation
    for (int i = 0; i < 20; i++) begin
      upd(32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); cycle();
    end
    stats(); look(32'h500, 1'b0, 32'h504); cycle();
    // Async reset asserted between edges, checked before any clock edge
    look(32'h200, 1'b0, 32'h204); cycle();
    rst = 1'b1;
    m_br = 0; m_mis = 0;
    stats(); look(32'h200, 1'b0, 32'h204);
    cycle();
    rst = 1'b0;
    stats(); look(32'h200, 1'b0, 32'h204); cycle();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
